// File: rtl/data_memory_2p.sv
// Two-port data memory: one write port, one registered read port, one clock.
// Optional post-reset clear sweep (busy while it runs) and out-of-range detect.
// Ports: clk, reset (sync, active-high), wen/waddr/write_data (write port),
//   ren/raddr (read request), read_data/read_valid (registered read result),
//   busy (clear sweep running), addr_err (previous access out of range).
// Macro DMEM_FWD_EN: same-address read/write returns write_data
//   (write-forward); undefined gives read-first (old data).
module data_memory_2p #(
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 8,
  parameter int DEPTH      = 1 << ADDR_W,
  parameter int CLR_ON_RST = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wen,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] write_data,
  input  logic              ren,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] read_data,
  output logic              read_valid,
  output logic              busy,
  output logic              addr_err
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] LAST = (ADDR_W+1)'(DEPTH - 1);

`ifdef DMEM_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  typedef enum logic {
    S_CLEAR,
    S_IDLE
  } state_t;

  state_t state;

  // One bit wider than the address so a full-depth sweep can reach LAST.
  logic [ADDR_W:0] cnt;

  logic [DATA_W-1:0] mem [DEPTH];

  logic w_bad;
  logic r_bad;
  logic w_ok;
  logic r_ok;
  logic hit;

  // A full-depth memory has no unreachable addresses.
  generate
    if (DEPTH < (1 << ADDR_W)) begin : g_range
      localparam logic [ADDR_W:0] DEP_C = (ADDR_W+1)'(DEPTH);
      assign w_bad = wen && ({1'b0, waddr} >= DEP_C);
      assign r_bad = ren && ({1'b0, raddr} >= DEP_C);
    end else begin : g_full
      assign w_bad = 1'b0;
      assign r_bad = 1'b0;
    end
  endgenerate

  assign w_ok = wen && !w_bad;
  assign r_ok = ren && !r_bad;
  assign hit  = FWD && w_ok && (waddr == raddr);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= (CLR_ON_RST != 0) ? S_CLEAR : S_IDLE;
      cnt        <= '0;
      busy       <= (CLR_ON_RST != 0);
      read_data  <= '0;
      read_valid <= 1'b0;
      addr_err   <= 1'b0;
    end else begin
      read_valid <= 1'b0;
      addr_err   <= 1'b0;
      unique case (state)
        S_CLEAR: begin
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        end
        S_IDLE: begin
          addr_err <= w_bad || r_bad;
          if (ren) begin
            read_valid <= 1'b1;
            if (!r_ok)
              read_data <= '0;
            else if (hit)
              read_data <= write_data;
            else
              read_data <= mem[raddr[IW-1:0]];
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Array kept free of reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == S_CLEAR)
        mem[cnt[IW-1:0]] <= '0;
      else if (w_ok)
        mem[waddr[IW-1:0]] <= write_data;
    end
  end

endmodule

// File: tb/tb_data_memory_2p.sv
// Bench for data_memory_2p: instance 0 is DEPTH=16 with clear sweep,
// instance 1 is DEPTH=200 without clear; both ADDR_W=8, DATA_W=8.
module tb_data_memory_2p;

`ifdef DMEM_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst [2];
  logic       wen [2];
  logic       ren [2];
  logic [7:0] wa  [2];
  logic [7:0] wd  [2];
  logic [7:0] ra  [2];
  logic [7:0] rd  [2];
  logic       rv  [2];
  logic       bsy [2];
  logic       er  [2];

  int total = 0;
  int bad = 0;

  data_memory_2p #(
    .DATA_W(8), .ADDR_W(8), .DEPTH(16), .CLR_ON_RST(1)
  ) u_a (
    .clk(clk), .reset(rst[0]),
    .wen(wen[0]), .waddr(wa[0]), .write_data(wd[0]),
    .ren(ren[0]), .raddr(ra[0]),
    .read_data(rd[0]), .read_valid(rv[0]),
    .busy(bsy[0]), .addr_err(er[0])
  );

  data_memory_2p #(
    .DATA_W(8), .ADDR_W(8), .DEPTH(200), .CLR_ON_RST(0)
  ) u_b (
    .clk(clk), .reset(rst[1]),
    .wen(wen[1]), .waddr(wa[1]), .write_data(wd[1]),
    .ren(ren[1]), .raddr(ra[1]),
    .read_data(rd[1]), .read_valid(rv[1]),
    .busy(bsy[1]), .addr_err(er[1])
  );

  function automatic int dep(input int i);
    return (i == 0) ? 16 : 200;
  endfunction

  function automatic bit clr(input int i);
    return i == 0;
  endfunction

  // Behavioural model: word array, remaining sweep cycles, expected outputs.
  logic [7:0] mm [2][256];
  int         left [2];
  logic [7:0] e_rd [2];
  logic       e_rv [2];
  logic       e_bs [2];
  logic       e_er [2];
  bit         live [2] = '{0, 0};

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      int d;
      logic [7:0] r;
      d = dep(i);
      if (rst[i]) begin
        left[i] <= clr(i) ? d : 0;
        e_bs[i] <= clr(i);
        e_rv[i] <= 1'b0;
        e_er[i] <= 1'b0;
        e_rd[i] <= 8'h00;
        live[i] <= 1'b1;
      end else if (left[i] > 0) begin
        mm[i][d - left[i]] <= 8'h00;
        left[i] <= left[i] - 1;
        e_bs[i] <= (left[i] > 1);
        e_rv[i] <= 1'b0;
        e_er[i] <= 1'b0;
      end else begin
        e_bs[i] <= 1'b0;
        e_rv[i] <= ren[i];
        e_er[i] <= (wen[i] && int'(wa[i]) >= d)
                || (ren[i] && int'(ra[i]) >= d);
        if (ren[i]) begin
          r = 8'h00;
          if (int'(ra[i]) < d) begin
            r = mm[i][ra[i]];
            if (FWD && wen[i] && wa[i] == ra[i])
              r = wd[i];
          end
          e_rd[i] <= r;
        end
        if (wen[i] && int'(wa[i]) < d)
          mm[i][wa[i]] <= wd[i];
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp,
               $time);
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (live[i]) begin
        chk($sformatf("m%0d_busy", i), 32'(bsy[i]), 32'(e_bs[i]));
        chk($sformatf("m%0d_rv", i), 32'(rv[i]), 32'(e_rv[i]));
        chk($sformatf("m%0d_err", i), 32'(er[i]), 32'(e_er[i]));
        chk($sformatf("m%0d_rd", i), 32'(rd[i]), 32'(e_rd[i]));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input int i, input bit w, input int a, input int d,
                     input bit r, input int b);
    wen[i] = w;
    wa[i]  = 8'(a);
    wd[i]  = 8'(d);
    ren[i] = r;
    ra[i]  = 8'(b);
  endtask

  task automatic idle();
    drv(0, 0, 0, 0, 0, 0);
    drv(1, 0, 0, 0, 0, 0);
  endtask

  task automatic rd_chk(input int i, input int a, input int exp,
                        input string nm);
    drv(i, 0, 0, 0, 1, a);
    step();
    chk({nm, "_data"}, 32'(rd[i]), 32'(exp));
    chk({nm, "_valid"}, 32'(rv[i]), 32'd1);
  endtask

  task automatic sweep_len(input string nm);
    int n;
    n = 0;
    while (bsy[0] && n < 100) begin
      n++;
      step();
    end
    chk(nm, 32'(n), 32'd16);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    rst[0] = 1'b1;
    rst[1] = 1'b1;
    step();
    step();
    chk("rst_busy_a", 32'(bsy[0]), 32'd1);
    chk("rst_busy_b", 32'(bsy[1]), 32'd0);
    chk("rst_rd_a", 32'(rd[0]), 32'd0);
    chk("rst_rv_a", 32'(rv[0]), 32'd0);
    rst[0] = 1'b0;
    rst[1] = 1'b0;

    // requests while sweeping must be ignored
    drv(0, 1, 5, 8'hFF, 1, 5);
    sweep_len("sweep_len");
    idle();
    for (int a = 0; a < 16; a++)
      rd_chk(0, a, 0, "clr");
    idle();
    step();
    chk("idle_rv", 32'(rv[0]), 32'd0);

    drv(0, 1, 3, 8'hA5, 0, 0);
    step();
    rd_chk(0, 3, 8'hA5, "basic");
    idle();
    step();
    chk("basic_rv0", 32'(rv[0]), 32'd0);
    chk("basic_hold", 32'(rd[0]), 32'hA5);

    drv(0, 1, 7, 8'h11, 0, 0);
    step();
    drv(0, 1, 7, 8'h22, 1, 7);
    step();
    chk("coll_data", 32'(rd[0]), FWD ? 32'h22 : 32'h11);
    rd_chk(0, 7, 8'h22, "coll_after");
    rd_chk(0, 16, 0, "a_oor");
    chk("a_oor_err", 32'(er[0]), 32'd1);
    idle();

    rst[0] = 1'b1;
    step();
    rst[0] = 1'b0;
    repeat (5) step();
    chk("mid_busy", 32'(bsy[0]), 32'd1);
    rst[0] = 1'b1;
    step();
    chk("mid_rst_busy", 32'(bsy[0]), 32'd1);
    rst[0] = 1'b0;
    sweep_len("resweep_len");
    rd_chk(0, 3, 0, "resweep3");
    rd_chk(0, 7, 0, "resweep7");
    idle();

    drv(1, 1, 9, 8'h3C, 0, 0);
    step();
    drv(1, 1, 199, 8'h77, 0, 0);
    step();
    idle();
    rst[1] = 1'b1;
    step();
    step();
    rst[1] = 1'b0;
    step();
    chk("ret_busy", 32'(bsy[1]), 32'd0);
    rd_chk(1, 9, 8'h3C, "ret9");
    rd_chk(1, 199, 8'h77, "ret199");
    drv(1, 1, 210, 8'h55, 0, 0);
    step();
    chk("oor_w_err", 32'(er[1]), 32'd1);
    idle();
    step();
    chk("oor_w_err0", 32'(er[1]), 32'd0);
    rd_chk(1, 9, 8'h3C, "oor_keep9");
    rd_chk(1, 210, 0, "oor_r");
    chk("oor_r_err", 32'(er[1]), 32'd1);
    drv(1, 1, 200, 8'h99, 0, 0);
    step();
    chk("oor_200", 32'(er[1]), 32'd1);
    drv(1, 1, 9, 8'h42, 1, 199);
    step();
    chk("indep_rd", 32'(rd[1]), 32'h77);
    rd_chk(1, 9, 8'h42, "indep_wr");
    rd_chk(1, 199, 8'h77, "keep199");
    idle();
    step();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
